// File: rtl/fifo_req_pkg.sv
// Shared request-word layout and FSM encodings for the depth-1 request FIFO
// writer and the fifo_req_issuer consumer.
package fifo_req_pkg;

   localparam int REQ_WIDTH    = 41;
   localparam int REQ_WE_BIT   = 40;
   localparam int REQ_ADDR_MSB = 39;
   localparam int REQ_ADDR_LSB = 32;
   localparam int REQ_DATA_MSB = 31;
   localparam int REQ_DATA_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } req_state_e;

   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } req_word_t;

   function automatic req_word_t decode_req(input logic [REQ_WIDTH-1:0] word);
      req_word_t r;
      r.we    = word[REQ_WE_BIT];
      r.addr  = word[REQ_ADDR_MSB:REQ_ADDR_LSB];
      r.wdata = word[REQ_DATA_MSB:REQ_DATA_LSB];
      return r;
   endfunction

endpackage

// File: rtl/req_timeout_ctr.sv
// Bus-request watchdog: counts cycles while enabled and flags the last
// allowed cycle (count == LIMIT-1). The owner leaves the guarded state on
// that flag, so the count never runs past LIMIT.
module req_timeout_ctr #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] TERM = W'(LIMIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // clear has priority so a fresh transaction always starts from zero
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable)
         cnt_d = cnt_q + 1'b1;
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = enable && (cnt_q == TERM);

endmodule

// File: rtl/fifo_req_issuer.sv
// Pops request words from the depth-1 request FIFO and runs each one as a
// req/ack transaction on the 8-bit-address peripheral bus, with a watchdog
// abort so a dead peripheral cannot stall the request path.
// Optional statistics counters: define FIFO_REQ_ISSUER_STATS_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a word; pops and latches bus fields when non-empty
// ST_ISSUE | bus_req high, fields stable, watchdog counting
// ST_DONE  | one-cycle bus turnaround, bus_req low, watchdog cleared
module fifo_req_issuer
   import fifo_req_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REQ_WIDTH-1:0] fifo_data,
   input  logic                 fifo_empty,
   output logic                 fifo_read_enable,
   output logic                 bus_req,
   output logic                 bus_we,
   output logic [7:0]           bus_addr,
   output logic [31:0]          bus_wdata,
   input  logic                 bus_ack,
   input  logic [31:0]          bus_rdata,
   output logic [31:0]          rd_data,
   output logic                 rd_valid,
   output logic                 busy,
   output logic                 timeout_err
`ifdef FIFO_REQ_ISSUER_STATS_EN
  ,output logic [15:0]          stat_done,
   output logic [15:0]          stat_timeout
`endif
);

   req_state_e  state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [7:0]  bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        timeout_err_q, timeout_err_d;
   logic        pop;
   logic        expired;
   req_word_t   req;

   assign req = decode_req(fifo_data);

   req_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q == ST_DONE),
      .enable  (state_q == ST_ISSUE),
      .expired (expired)
   );

   // next-state and registered-output decode; an ack on the watchdog's last
   // cycle is a normal completion, not an abort
   always_comb begin
      state_d       = state_q;
      bus_req_d     = bus_req_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_wdata_d   = bus_wdata_q;
      rd_data_d     = rd_data_q;
      rd_valid_d    = 1'b0;
      timeout_err_d = 1'b0;
      pop           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               bus_we_d    = req.we;
               bus_addr_d  = req.addr;
               bus_wdata_d = req.wdata;
               bus_req_d   = 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus_ack) begin
               bus_req_d = 1'b0;
               if (!bus_we_q) begin
                  rd_data_d  = bus_rdata;
                  rd_valid_d = 1'b1;
               end
               state_d = ST_DONE;
            end else if (expired) begin
               bus_req_d     = 1'b0;
               timeout_err_d = 1'b1;
               if (!bus_we_q) begin
                  rd_data_d  = TIMEOUT_RDATA;
                  rd_valid_d = 1'b1;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bus_req_d = 1'b0;
            state_d   = ST_IDLE;
         end
         default: begin
            bus_req_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // state and output registers; reset also kills any in-flight transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_wdata_q   <= '0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_wdata_q   <= bus_wdata_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // gated by rst so a pop can never be lost into a reset edge
   assign fifo_read_enable = pop && !rst;
   assign bus_req          = bus_req_q;
   assign bus_we           = bus_we_q;
   assign bus_addr         = bus_addr_q;
   assign bus_wdata        = bus_wdata_q;
   assign rd_data          = rd_data_q;
   assign rd_valid         = rd_valid_q;
   assign timeout_err      = timeout_err_q;
   assign busy             = (state_q != ST_IDLE);

`ifdef FIFO_REQ_ISSUER_STATS_EN
   logic [15:0] stat_done_q, stat_timeout_q;
   logic        done_entry;

   assign done_entry = (state_q == ST_ISSUE) && (state_d == ST_DONE);

   // saturating transaction / abort counters, bumped on the DONE-entry edge
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_done_q    <= '0;
         stat_timeout_q <= '0;
      end else begin
         if (done_entry && (stat_done_q != 16'hFFFF))
            stat_done_q <= stat_done_q + 16'd1;
         if (timeout_err_d && (stat_timeout_q != 16'hFFFF))
            stat_timeout_q <= stat_timeout_q + 16'd1;
      end
   end

   assign stat_done    = stat_done_q;
   assign stat_timeout = stat_timeout_q;
`endif

endmodule

// File: tb/tb_fifo_req_issuer.sv
// Directed bench for fifo_req_issuer with a 4-cycle watchdog.
module tb_fifo_req_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic [40:0] fifo_data;
   logic        fifo_empty;
   logic        fifo_read_enable;
   logic        bus_req;
   logic        bus_we;
   logic [7:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic        timeout_err;
`ifdef FIFO_REQ_ISSUER_STATS_EN
   logic [15:0] stat_done;
   logic [15:0] stat_timeout;
`endif

   int checks = 0;
   int errors = 0;

   int req_hi_cnt    = 0;
   int rv_cnt        = 0;
   int to_cnt        = 0;
   int pop_cnt       = 0;
   int pop_empty_cnt = 0;

   always #5 clk = ~clk;

   fifo_req_issuer #(
      .TIMEOUT_CYCLES (4),
      .TIMEOUT_RDATA  (32'hFFFF_FFFF)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .fifo_data        (fifo_data),
      .fifo_empty       (fifo_empty),
      .fifo_read_enable (fifo_read_enable),
      .bus_req          (bus_req),
      .bus_we           (bus_we),
      .bus_addr         (bus_addr),
      .bus_wdata        (bus_wdata),
      .bus_ack          (bus_ack),
      .bus_rdata        (bus_rdata),
      .rd_data          (rd_data),
      .rd_valid         (rd_valid),
      .busy             (busy),
      .timeout_err      (timeout_err)
`ifdef FIFO_REQ_ISSUER_STATS_EN
     ,.stat_done        (stat_done),
      .stat_timeout     (stat_timeout)
`endif
   );

   // per-cycle event counters, sampled mid-cycle
   always @(negedge clk) begin
      if (bus_req)     req_hi_cnt <= req_hi_cnt + 1;
      if (rd_valid)    rv_cnt     <= rv_cnt + 1;
      if (timeout_err) to_cnt     <= to_cnt + 1;
      if (fifo_read_enable) begin
         pop_cnt <= pop_cnt + 1;
         if (fifo_empty) pop_empty_cnt <= pop_empty_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      fifo_empty = 1'b1;
      fifo_data  = '0;
      bus_ack    = 1'b0;
      bus_rdata  = '0;
      tick();
      tick();
      checks++; if ({bus_req, bus_we, rd_valid, timeout_err, busy} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {bus_req, bus_we, rd_valid, timeout_err, busy}); end
      checks++; if ({bus_addr, bus_wdata, rd_data} !== 72'h0) begin errors++; $display("FAIL reset_fields got %h exp 0", {bus_addr, bus_wdata, rd_data}); end
      fifo_data  = {1'b1, 8'hEE, 32'h0000_00EE};
      fifo_empty = 1'b0;
      #1;
      checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL reset_pop_gate got %b exp 0", fifo_read_enable); end
      fifo_empty = 1'b1;
      rst        = 1'b0;
      tick();
      bus_ack = 1'b1;
      tick();
      tick();
      bus_ack = 1'b0;
      checks++; if ({busy, bus_req, rd_valid} !== 3'b000) begin errors++; $display("FAIL stray_ack got %b exp 000", {busy, bus_req, rd_valid}); end
   endtask

   task automatic test_write();
      int r0;
      r0 = rv_cnt;
      fifo_data  = {1'b1, 8'h12, 32'hCAFE_0001};
      fifo_empty = 1'b0;
      #1;
      checks++; if (fifo_read_enable !== 1'b1) begin errors++; $display("FAIL wr_pop got %b exp 1", fifo_read_enable); end
      tick();
      fifo_empty = 1'b1;
      #1;
      checks++; if (fifo_read_enable !== 1'b0) begin errors++; $display("FAIL wr_pop_once got %b exp 0", fifo_read_enable); end
      checks++; if ({bus_req, bus_we, busy} !== 3'b111) begin errors++; $display("FAIL wr_issue_flags got %b exp 111", {bus_req, bus_we, busy}); end
      checks++; if ({bus_addr, bus_wdata} !== {8'h12, 32'hCAFE_0001}) begin errors++; $display("FAIL wr_fields got %h exp 12cafe0001", {bus_addr, bus_wdata}); end
      tick();
      tick();
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      checks++; if ({bus_req, busy, rd_valid} !== 3'b010) begin errors++; $display("FAIL wr_done got %b exp 010", {bus_req, busy, rd_valid}); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy got %b exp 0", busy); end
      tick();
      checks++; if (busy !== 1'b0 || rv_cnt != r0) begin errors++; $display("FAIL wr_no_rdvalid busy %b rd_valid_pulses %0d exp 0", busy, rv_cnt - r0); end
   endtask

   task automatic test_read();
      fifo_data  = {1'b0, 8'h34, 32'h0BAD_F00D};
      fifo_empty = 1'b0;
      tick();
      fifo_empty = 1'b1;
      bus_ack    = 1'b1;
      bus_rdata  = 32'h1234_5678;
      #1;
      checks++; if ({bus_we, bus_addr} !== {1'b0, 8'h34}) begin errors++; $display("FAIL rd_fields got %h exp 034", {bus_we, bus_addr}); end
      tick();
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      checks++; if ({rd_valid, bus_req, timeout_err} !== 3'b100) begin errors++; $display("FAIL rd_valid_pulse got %b exp 100", {rd_valid, bus_req, timeout_err}); end
      checks++; if (rd_data !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h exp 12345678", rd_data); end
      tick();
      checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h1234_5678) begin errors++; $display("FAIL rd_hold got %b/%h exp 0/12345678", rd_valid, rd_data); end
   endtask

   task automatic test_timeout();
      int h0, t0, r0;
      h0 = req_hi_cnt; t0 = to_cnt; r0 = rv_cnt;
      fifo_data  = {1'b0, 8'h56, 32'h0};
      fifo_empty = 1'b0;
      tick();
      fifo_empty = 1'b1;
      tick();
      tick();
      tick();
      checks++; if ({bus_req, timeout_err} !== 2'b10) begin errors++; $display("FAIL to_last_cycle got %b exp 10", {bus_req, timeout_err}); end
      tick();
      checks++; if ({bus_req, timeout_err, rd_valid} !== 3'b011) begin errors++; $display("FAIL to_abort got %b exp 011", {bus_req, timeout_err, rd_valid}); end
      checks++; if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_rdata got %h exp ffffffff", rd_data); end
      checks++; if (req_hi_cnt - h0 != 4) begin errors++; $display("FAIL to_req_cycles got %0d exp 4", req_hi_cnt - h0); end
      tick();
      checks++; if (to_cnt - t0 != 1 || rv_cnt - r0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL to_pulses got to=%0d rv=%0d busy=%b exp 1/1/0", to_cnt - t0, rv_cnt - r0, busy); end

      // ack on the watchdog's final cycle completes normally
      fifo_data  = {1'b0, 8'h78, 32'h0};
      fifo_empty = 1'b0;
      tick();
      fifo_empty = 1'b1;
      tick();
      tick();
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'hAAAA_5555;
      tick();
      bus_ack = 1'b0;
      checks++; if ({rd_valid, timeout_err} !== 2'b10 || rd_data !== 32'hAAAA_5555) begin errors++; $display("FAIL ack_at_limit got %b/%h exp 10/aaaa5555", {rd_valid, timeout_err}, rd_data); end
      tick();

      // write timeout: error pulse only, read result untouched
      fifo_data  = {1'b1, 8'h9A, 32'h55};
      fifo_empty = 1'b0;
      tick();
      fifo_empty = 1'b1;
      tick();
      tick();
      tick();
      tick();
      checks++; if ({timeout_err, rd_valid} !== 2'b10 || rd_data !== 32'hAAAA_5555) begin errors++; $display("FAIL wr_timeout got %b/%h exp 10/aaaa5555", {timeout_err, rd_valid}, rd_data); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [40:0] w [3];
      logic        hist [16];
      logic        popped;
      int          idx, rises, low_run;
      w[0] = {1'b1, 8'hA0, 32'h0000_0001};
      w[1] = {1'b1, 8'hA1, 32'h0000_0002};
      w[2] = {1'b1, 8'hA2, 32'h0000_0003};
      idx        = 0;
      fifo_data  = w[0];
      fifo_empty = 1'b0;
      bus_ack    = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         popped = fifo_read_enable;
         tick();
         if (popped) begin
            checks++; if ({bus_addr, bus_wdata} !== w[idx][39:0]) begin errors++; $display("FAIL b2b_fields[%0d] got %h exp %h", idx, {bus_addr, bus_wdata}, w[idx][39:0]); end
            idx++;
            if (idx < 3) fifo_data = w[idx];
            else         fifo_empty = 1'b1;
         end
         hist[c] = bus_req;
      end
      bus_ack = 1'b0;
      // each gap is the DONE turnaround cycle plus the IDLE pop cycle
      rises   = 0;
      low_run = 0;
      for (int c = 0; c < 16; c++) begin
         if (hist[c]) begin
            if (c == 0 || !hist[c-1]) begin
               if (rises > 0) begin
                  checks++; if (low_run != 2) begin errors++; $display("FAIL b2b_gap got %0d exp 2", low_run); end
               end
               rises++;
            end
            low_run = 0;
         end else begin
            low_run++;
         end
      end
      checks++; if (rises != 3) begin errors++; $display("FAIL b2b_requests got %0d exp 3", rises); end
   endtask

   task automatic test_reset_mid_issue();
      int p0, r0, t0;
      p0 = pop_cnt; r0 = rv_cnt; t0 = to_cnt;
      fifo_data  = {1'b0, 8'hBC, 32'h0};
      fifo_empty = 1'b0;
      tick();
      fifo_empty = 1'b1;
      tick();
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmi_pre got %b exp 1", bus_req); end
      rst = 1'b1;
      tick();
      checks++; if ({bus_req, busy, bus_we, rd_valid, timeout_err} !== 5'b0) begin errors++; $display("FAIL rmi_flags got %b exp 00000", {bus_req, busy, bus_we, rd_valid, timeout_err}); end
      checks++; if ({bus_addr, bus_wdata, rd_data} !== 72'h0) begin errors++; $display("FAIL rmi_fields got %h exp 0", {bus_addr, bus_wdata, rd_data}); end
      rst = 1'b0;
      tick();
      tick();
      checks++; if (rv_cnt != r0 || to_cnt != t0 || pop_cnt - p0 != 1) begin errors++; $display("FAIL rmi_events got rv=%0d to=%0d pops=%0d exp 0/0/1", rv_cnt - r0, to_cnt - t0, pop_cnt - p0); end
   endtask

`ifdef FIFO_REQ_ISSUER_STATS_EN
   task automatic run_txn(input logic we, input logic [7:0] a, input int ack_at);
      fifo_data  = {we, a, 32'h0};
      fifo_empty = 1'b0;
      tick();
      fifo_empty = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c == ack_at) bus_ack = 1'b1;
         tick();
         bus_ack = 1'b0;
         if (!bus_req) break;
      end
      tick();
   endtask

   task automatic test_stats();
      checks++; if ({stat_done, stat_timeout} !== 32'h0) begin errors++; $display("FAIL stats_reset got %h exp 0", {stat_done, stat_timeout}); end
      run_txn(1'b1, 8'h01, 0);
      run_txn(1'b0, 8'h02, 1);
      run_txn(1'b0, 8'h03, -1);
      checks++; if (stat_done !== 16'd3) begin errors++; $display("FAIL stat_done got %0d exp 3", stat_done); end
      checks++; if (stat_timeout !== 16'd1) begin errors++; $display("FAIL stat_timeout got %0d exp 1", stat_timeout); end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_back_to_back();
      test_reset_mid_issue();
`ifdef FIFO_REQ_ISSUER_STATS_EN
      test_stats();
`endif
      tick();
      checks++; if (pop_empty_cnt != 0) begin errors++; $display("FAIL pop_while_empty got %0d exp 0", pop_empty_cnt); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
